// File: rtl/rriot_pkg.sv
// Shared types and constants for the RRIOT interval timer: divider codes,
// timer states, register-address bit positions and the prescale reload map.
package rriot_pkg;

  typedef enum logic [1:0] {
    DIV1    = 2'd0,
    DIV8    = 2'd1,
    DIV64   = 2'd2,
    DIV1024 = 2'd3
  } div_code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  localparam int unsigned ADDR_TIMER_BIT  = 2;
  localparam int unsigned ADDR_STATUS_BIT = 0;
  localparam int unsigned ADDR_IRQEN_BIT  = 3;

  // Reload value is divide ratio minus one, so the prescaler ticks every D cycles.
  function automatic logic [9:0] presc_reload(input div_code_t code);
    case (code)
      DIV1:    return 10'd0;
      DIV8:    return 10'd7;
      DIV64:   return 10'd63;
      default: return 10'd1023;
    endcase
  endfunction

endpackage

// File: rtl/rriot_timer_if.sv
// Register bus shared by the RRIOT timer and I/O block.
interface rriot_timer_if;
  logic       cs;
  logic       we_n;
  logic [3:0] A;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       OE;
  logic       IRQ_n;

  modport master (output cs, we_n, A, DI, input DO, OE, IRQ_n);
  modport slave  (input cs, we_n, A, DI, output DO, OE, IRQ_n);
endinterface

// File: rtl/rriot_prescaler.sv
// 10-bit prescale down-counter producing a one-cycle tick; bypass forces a
// tick every cycle (divide-by-1 while the timer is expired).
module rriot_prescaler
  import rriot_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic       bypass,
  input  logic [9:0] reload,
  output logic       tick
);

  logic [9:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = reload;
    end else if (run && !bypass) begin
      presc_d = (presc_q == 10'd0) ? reload : presc_q - 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= 10'd0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = bypass | (run & (presc_q == 10'd0));

endmodule

// File: rtl/rriot_timer.sv
// RRIOT interval timer: programmable 8-bit down-counter with prescaler and
// underflow flag. Optional IRQ enable via macro RRIOT_TIMER_IRQ_EN.
module rriot_timer
  import rriot_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  rriot_timer_if.slave bus
);

  timer_state_t state_q, state_d;
  div_code_t    div_q, div_d;
  logic [7:0]   count_q, count_d;
  logic [7:0]   do_q, do_d;
  logic         flag_q, flag_d;
  logic         oe_q, oe_d;

  logic       acc, wr, rd_timer, rd_status;
  logic       tick, load, underflow, run, bypass;
  logic [9:0] reload;

  assign acc       = bus.cs & bus.A[ADDR_TIMER_BIT];
  assign wr        = acc & ~bus.we_n;
  assign rd_timer  = acc & bus.we_n & ~bus.A[ADDR_STATUS_BIT];
  assign rd_status = acc & bus.we_n & bus.A[ADDR_STATUS_BIT];

  assign run       = (state_q == COUNT);
  assign bypass    = (state_q == EXPIRED);
  // A write must load the ratio it is programming, not the stale one.
  assign reload    = presc_reload(wr ? div_code_t'(bus.A[1:0]) : div_q);
  assign load      = wr | (rd_timer & (state_q == EXPIRED));
  assign underflow = tick & (count_q == 8'd0);

  rriot_prescaler u_presc (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .run    (run),
    .bypass (bypass),
    .reload (reload),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    count_d = count_q;
    flag_d  = flag_q;
    do_d    = do_q;
    oe_d    = rd_timer | rd_status;

    if (rd_timer) begin
      do_d = count_q;
    end else if (rd_status) begin
      do_d = {flag_q, 7'b0};
    end

    if (wr) begin
      count_d = bus.DI;
      div_d   = div_code_t'(bus.A[1:0]);
      flag_d  = 1'b0;
      state_d = COUNT;
    end else begin
      if (tick) begin
        count_d = count_q - 8'd1;
      end
      if (rd_timer) begin
        flag_d = 1'b0;
        if (state_q == EXPIRED) begin
          state_d = COUNT;
        end
      end
      // Underflow is applied last so it beats a coincident timer read.
      if (underflow) begin
        flag_d  = 1'b1;
        state_d = EXPIRED;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= DIV1;
      count_q <= 8'd0;
      flag_q  <= 1'b0;
      do_q    <= 8'd0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      do_q    <= do_d;
      oe_q    <= oe_d;
    end
  end

  assign bus.DO = do_q;
  assign bus.OE = oe_q;

`ifdef RRIOT_TIMER_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr || rd_timer) begin
      irq_en_d = bus.A[ADDR_IRQEN_BIT];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
    end
  end

  assign bus.IRQ_n = ~(flag_q & irq_en_q);
`else
  assign bus.IRQ_n = 1'b1;
`endif

endmodule

// File: tb/tb_rriot_timer.sv
// Self-checking bench for rriot_timer: vector table, directed corner cases and
// randomized traffic against a cycle-level reference model of the timer rules.
module tb_rriot_timer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rriot_timer_if bus ();

  rriot_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model state, in plain integers.
  int         m_count, m_presc, m_div;
  bit         m_run, m_exp, m_flag, m_irqen, m_oe;
  logic [7:0] m_do;

  function automatic int div_of(input logic [1:0] code);
    case (code)
      2'd0:    return 1;
      2'd1:    return 8;
      2'd2:    return 64;
      default: return 1024;
    endcase
  endfunction

  function automatic bit model_irq_n();
`ifdef RRIOT_TIMER_IRQ_EN
    return !(m_flag && m_irqen);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_div = 1;
    m_run = 0; m_exp = 0; m_flag = 0; m_irqen = 0; m_oe = 0;
    m_do = 8'h00;
  endtask

  task automatic model_step(input bit cs, input bit we_n, input logic [3:0] a, input logic [7:0] di);
    bit acc, wr, rt, rs, tick, uf;
    acc = cs && a[2];
    wr  = acc && !we_n;
    rt  = acc && we_n && !a[0];
    rs  = acc && we_n && a[0];
    if (rt) m_do = 8'(m_count);
    else if (rs) m_do = m_flag ? 8'h80 : 8'h00;
    m_oe = rt || rs;
    if (wr) begin
      m_count = int'(di);
      m_div   = div_of(a[1:0]);
      m_presc = m_div - 1;
      m_irqen = a[3];
      m_flag  = 0;
      m_run   = 1;
      m_exp   = 0;
    end else begin
      tick = m_exp || (m_run && m_presc == 0);
      uf   = tick && (m_count == 0);
      if (m_run && !m_exp) m_presc = (m_presc == 0) ? m_div - 1 : m_presc - 1;
      if (tick) m_count = (m_count + 255) % 256;
      if (rt) begin
        m_irqen = a[3];
        m_flag  = 0;
        if (m_exp) begin
          m_exp   = 0;
          m_presc = m_div - 1;
        end
      end
      if (uf) begin
        m_flag = 1;
        m_exp  = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".DO"}, 32'(bus.DO), 32'(m_do));
    check({tag, ".OE"}, 32'(bus.OE), 32'(m_oe));
    check({tag, ".IRQ_n"}, 32'(bus.IRQ_n), 32'(model_irq_n()));
  endtask

  // One bus cycle: drive, clock, advance model, settle.
  task automatic cycle(input bit cs, input bit we_n, input logic [3:0] a, input logic [7:0] di,
                       input bit show);
    bus.cs = cs; bus.we_n = we_n; bus.A = a; bus.DI = di;
    @(posedge clk);
    model_step(cs, we_n, a, di);
    #1;
    txn++;
    if (show)
      $display("txn %0d cs=%0b we_n=%0b A=%b DI=%h -> DO=%h OE=%0b IRQ_n=%0b",
               txn, cs, we_n, a, di, bus.DO, bus.OE, bus.IRQ_n);
  endtask

  task automatic do_reset();
    bus.cs = 1'b0; bus.we_n = 1'b1; bus.A = 4'h0; bus.DI = 8'h00;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  typedef struct {
    bit         cs;
    bit         we_n;
    logic [3:0] a;
    logic [7:0] di;
    logic [7:0] exp_do;
    bit         exp_oe;
    bit         exp_irq_n;
  } vec_t;

  vec_t vecs[12];
  bit   irq_low;

  initial begin
`ifdef RRIOT_TIMER_IRQ_EN
    irq_low = 1'b0;
`else
    irq_low = 1'b1;
`endif
    // Write 05 at div 1, then watch it count down and underflow.
    vecs[0]  = '{1, 1, 4'b0101, 8'h00, 8'h00, 1, 1};
    vecs[1]  = '{0, 1, 4'b0100, 8'h00, 8'h00, 0, 1};
    vecs[2]  = '{1, 1, 4'b0100, 8'h00, 8'h00, 1, 1};
    vecs[3]  = '{1, 0, 4'b1100, 8'h05, 8'h00, 0, 1};
    vecs[4]  = '{1, 1, 4'b0100, 8'h00, 8'h05, 1, 1};
    vecs[5]  = '{1, 1, 4'b0100, 8'h00, 8'h04, 1, 1};
    vecs[6]  = '{1, 1, 4'b0000, 8'h00, 8'h04, 0, 1};
    vecs[7]  = '{1, 1, 4'b0100, 8'h00, 8'h02, 1, 1};
    vecs[8]  = '{0, 1, 4'b0100, 8'h00, 8'h02, 0, 1};
    vecs[9]  = '{0, 1, 4'b0100, 8'h00, 8'h02, 0, 1};
    vecs[10] = '{1, 1, 4'b0101, 8'h00, 8'h80, 1, 1};
    vecs[11] = '{1, 1, 4'b0101, 8'h00, 8'h80, 1, 1};

    do_reset();
    check("reset.DO", 32'(bus.DO), 32'h00);
    check("reset.OE", 32'(bus.OE), 32'h0);
    check("reset.IRQ_n", 32'(bus.IRQ_n), 32'h1);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].cs, vecs[i].we_n, vecs[i].a, vecs[i].di, 1'b1);
      check($sformatf("vec%0d.DO", i), 32'(bus.DO), 32'(vecs[i].exp_do));
      check($sformatf("vec%0d.OE", i), 32'(bus.OE), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d.IRQ_n", i), 32'(bus.IRQ_n), 32'(vecs[i].exp_irq_n));
    end

    // Divide-by-8 count of 03 with IRQ enabled.
    do_reset();
    cycle(1, 0, 4'b1101, 8'h03, 1'b1);
    for (int k = 1; k <= 44; k++) begin
      case (k)
        8, 16, 24, 25, 35, 43, 44: cycle(1, 1, 4'b1100, 8'h00, 1'b1);
        33, 34:                    cycle(1, 1, 4'b0101, 8'h00, 1'b1);
        default:                   cycle(0, 1, 4'b0000, 8'h00, 1'b1);
      endcase
      check_model($sformatf("div8.e%0d", k));
      case (k)
        8:  check("div8.cnt03", 32'(bus.DO), 32'h03);
        16: check("div8.cnt02", 32'(bus.DO), 32'h02);
        24: check("div8.cnt01", 32'(bus.DO), 32'h01);
        25: check("div8.cnt00", 32'(bus.DO), 32'h00);
        31: check("div8.irq_before", 32'(bus.IRQ_n), 32'h1);
        32: check("div8.irq_at_uf", 32'(bus.IRQ_n), 32'(irq_low));
        33: check("status.first", 32'(bus.DO), 32'h80);
        34: begin
          check("status.repeat", 32'(bus.DO), 32'h80);
          check("status.irq_held", 32'(bus.IRQ_n), 32'(irq_low));
        end
        35: begin
          check("clr.DO", 32'(bus.DO), 32'hFD);
          check("clr.OE", 32'(bus.OE), 32'h1);
          check("clr.IRQ_n", 32'(bus.IRQ_n), 32'h1);
        end
        36: check("clr.OE_drop", 32'(bus.OE), 32'h0);
        43: check("resume.FC", 32'(bus.DO), 32'hFC);
        44: check("resume.FB", 32'(bus.DO), 32'hFB);
        default: ;
      endcase
    end

    // Write on the exact underflow cycle.
    do_reset();
    cycle(1, 0, 4'b0100, 8'h00, 1'b1);
    cycle(1, 0, 4'b0100, 8'h10, 1'b1);
    cycle(1, 1, 4'b0100, 8'h00, 1'b1);
    check("coll.count10", 32'(bus.DO), 32'h10);
    cycle(1, 1, 4'b0101, 8'h00, 1'b1);
    check("coll.flag0", 32'(bus.DO), 32'h00);
    cycle(1, 1, 4'b0100, 8'h00, 1'b1);
    check("coll.counting", 32'(bus.DO), 32'h0E);

    // Asynchronous reset while flag set and DO/OE active.
    do_reset();
    cycle(1, 0, 4'b1100, 8'h00, 1'b1);
    cycle(0, 1, 4'b0000, 8'h00, 1'b1);
    cycle(1, 1, 4'b0101, 8'h00, 1'b1);
    check("pre_rst.DO", 32'(bus.DO), 32'h80);
    check("pre_rst.IRQ_n", 32'(bus.IRQ_n), 32'(irq_low));
    bus.cs = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("midrst.DO", 32'(bus.DO), 32'h00);
    check("midrst.OE", 32'(bus.OE), 32'h0);
    check("midrst.IRQ_n", 32'(bus.IRQ_n), 32'h1);
    #3 reset = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      cycle(0, 1, 4'b0100, 8'h00, 1'b0);
      if (bus.IRQ_n !== 1'b1 || bus.OE !== 1'b0) check_model("idle");
    end
    cycle(1, 1, 4'b0101, 8'h00, 1'b1);
    check("idle.noflag", 32'(bus.DO), 32'h00);
    cycle(1, 1, 4'b0100, 8'h00, 1'b1);
    check("idle.count0", 32'(bus.DO), 32'h00);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      int unsigned r;
      logic [3:0]  a;
      r = $urandom_range(0, 99);
      a = 4'($urandom);
      if (r < 6) begin
        a[2] = 1'b1;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 1));
        cycle(1, 0, a, 8'($urandom_range(0, 20)), 1'b1);
      end else if (r < 35) begin
        cycle(1, 1, a, 8'($urandom), 1'b1);
      end else begin
        cycle(1'($urandom), 1'b1, a, 8'($urandom), 1'b1);
      end
      check_model($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rriot_timer.md
# rriot_timer

Interval timer of the RRIOT, sharing the register bus with the port A/B I/O block. Decodes timer accesses (A[2]=1) from the same `we_n`/`A`/`DI` bus, counts down a programmed 8-bit value at a selectable prescale, and raises an interrupt flag on underflow. Its `IRQ_n` output is the value the system routes to the I/O block's PB7 input.

## Interface
- No parameters.
- `clk` in 1: system clock, one tick per bus cycle.
- `reset` in 1: asynchronous, active-high.
- `cs` in 1: chip/region select from the address decoder; accesses are ignored when low.
- `we_n` in 1: 0 = write, 1 = read.
- `A` in 4: register address; A[2]=1 selects the timer, A[1:0] select the divider on writes, A[3] is the IRQ enable.
- `DI` in 8: write data.
- `DO` out 8: read data.
- `OE` out 1: `DO` valid; high for exactly one cycle after a read access.
- `IRQ_n` out 1: active-low interrupt, `!(flag & irq_en)`.

## Operation
- **Access qualifier:** `acc = cs & A[2]`.
- **Write** (`acc & !we_n`):
  - `count <= DI`
  - `div <= {1,8,64,1024}[A[1:0]]`
  - `presc <= div-1`
  - `irq_en <= A[3]`
  - `flag <= 0`
  - state → COUNT
- **Read timer** (`acc & we_n & !A[0]`):
  - `DO <= count` (pre-update value)
  - `OE <= 1`
  - `irq_en <= A[3]`
  - `flag <= 0`
  - if EXPIRED: state → COUNT, `presc <= div-1`
- **Read status** (`acc & we_n & A[0]`):
  - `DO <= {flag, 7'b0}`
  - `OE <= 1`
  - flag not cleared
- **No read this cycle:** `OE <= 0`; `DO` holds its value.
- **States:**
  - IDLE: after reset; counter frozen, no underflow possible.
  - COUNT: decrement `count` when `presc == 0`, then `presc <= div-1`; otherwise `presc <= presc-1`.
  - EXPIRED: entered on underflow; decrements `count` every cycle (divide-by-1).
- **Underflow:** in COUNT with `presc == 0` and `count == 0`:
  - `count <= 8'hFF`
  - `flag <= 1`
  - state → EXPIRED
- **Underflow in EXPIRED:** `count` wraps 00 → FF; flag stays 1; state stays EXPIRED.
- **Simultaneous events:**
  - A write in the same cycle as an underflow: the write wins completely.
  - A timer read in the same cycle as an underflow: the set wins (`flag = 1`), and the state goes to EXPIRED.
- **Width:** `presc` is 10 bits. The divider is stored as a 2-bit code. All counter arithmetic is modulo its width.

## Timing
- **Reset values:** `DO = 0`, `OE = 0`, `IRQ_n = 1`, `count = 0`, `presc = 0`, div code = 0 (÷1), `flag = 0`, `irq_en = 0`, state IDLE. Reset mid-count aborts immediately to these values.
- Write of N at ÷D on edge 0: `count` reads N until edge D, then N−1.
- Underflow occurs D·(N+1) edges after the write; the flag and `IRQ_n` are visible after that edge.
- `IRQ_n` is combinational from registered `flag`/`irq_en`, with no extra latency.
- Read latency: `DO`/`OE` are valid one cycle after the access edge.

## Configuration
- **`RRIOT_TIMER_IRQ_EN` defined:** `irq_en` register and `IRQ_n` behave as specified.
- **Not defined:**
  - `irq_en` is removed and A[3] is ignored.
  - `IRQ_n` is tied to 1.
  - `flag` still operates and remains readable via the status register.

## Structure
- **Package `rriot_pkg`:**
  - divider code enum: DIV1, DIV8, DIV64, DIV1024
  - function mapping code → prescale reload value
  - timer state enum: IDLE, COUNT, EXPIRED
  - address bit constants for the timer select, status select and IRQ-enable bits
- **Sub-module `rriot_prescaler`:**
  - 10-bit down-counter
  - inputs: load, reload value, bypass (EXPIRED)
  - output: a one-cycle `tick`

## Test plan
- **Reset:** assert `reset` mid-count → `DO=00`, `OE=0`, `IRQ_n=1`, state IDLE; no flag set after 2000 cycles.
- **Divide-by-8 count:** write 8'h03 at A=4'b1101 (÷8, IRQ en) → count 03,02,01,00 each 8 cycles; flag set and `IRQ_n=0` 32 edges after the write; `count` then reads FE, FD on successive cycles.
- **Clear on timer read:** after underflow, read A=4'b1100 → `DO` = current count, `OE` high one cycle, flag=0, `IRQ_n=1`; ÷8 rate resumes.
- **Status read does not clear:** read A=4'b0101 after underflow → `DO=8'h80`; the flag stays set on a repeat read.
- **Write vs underflow collision:** write 8'h10 ÷1 on the exact underflow cycle → flag=0, `count=10`, state COUNT.
- **Macro off:** with `RRIOT_TIMER_IRQ_EN` undefined, run the divide-by-8 scenario → `IRQ_n` stays 1, status read returns 8'h80.
